// File: rtl/fabric_ccff_loader.sv
// fabric_ccff_loader: takes host words and shifts them LSB-first into the fabric configuration chain (ccff_head).
// Latency: ccff_head/ccff_shift_en are registered, one cycle behind SHIFT; at least one bubble cycle between words.
// Backpressure: word_ready only in WAIT_WORD, chain frozen while host stalls; FABRIC_CCFF_READBACK_EN adds rd_valid/rd_data (never stalls).
module fabric_ccff_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 4096,
    parameter int CNT_W     = 13
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef FABRIC_CCFF_READBACK_EN
    ,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data
`endif
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   total_cnt_q, total_cnt_d;
    logic               word_ready_q, word_ready_d;
    logic               head_q, head_d;
    logic               shift_en_q, shift_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        total_cnt_d = total_cnt_q;
        head_d      = head_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT_WORD;
                    total_cnt_d = '0;
                end
            end
            S_WAIT_WORD: begin
                if (word_valid && word_ready_q) begin
                    shreg_d   = word_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                head_d      = shreg_q[0];
                shreg_d     = shreg_q >> 1;
                bit_cnt_d   = bit_cnt_q + 1'b1;
                total_cnt_d = total_cnt_q + 1'b1;
                // Chain-full wins over word-empty so leftover bits of the last word are dropped.
                if (total_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = S_DONE;
                end else if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                    state_d = S_WAIT_WORD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        word_ready_d = (state_d == S_WAIT_WORD);
        shift_en_d   = (state_q == S_SHIFT);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            total_cnt_q  <= '0;
            word_ready_q <= 1'b0;
            head_q       <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            total_cnt_q  <= total_cnt_d;
            word_ready_q <= word_ready_d;
            head_q       <= head_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign word_ready    = word_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef FABRIC_CCFF_READBACK_EN
    logic [WORD_W-1:0] rd_word_q, rd_word_d;
    logic [WORD_W-1:0] rd_word_nxt;
    logic [BIT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;

    // The last chain edge of a load coincides with done_q, which flushes a partial word.
    always_comb begin
        rd_word_d   = rd_word_q;
        rd_cnt_d    = rd_cnt_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_word_nxt = rd_word_q;
        if (shift_en_q) begin
            rd_word_nxt[rd_cnt_q] = ccff_tail;
            if ((rd_cnt_q == BIT_W'(WORD_W - 1)) || done_q) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rd_word_nxt;
                rd_word_d  = '0;
                rd_cnt_d   = '0;
            end else begin
                rd_word_d = rd_word_nxt;
                rd_cnt_d  = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            rd_word_q  <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_word_q  <= rd_word_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_fabric_ccff_loader.sv
// Bench: two loaders (CHAIN_LEN 8 and 6, WORD_W 4) share host stimulus; each drives its own behavioural chain.
module tb_fabric_ccff_loader;

    logic       prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       pReset, start, word_valid;
    logic [3:0] word_data;
    logic       rdy8, head8, sen8, tail8, busy8, done8;
    logic       rdy6, head6, sen6, tail6, busy6, done6;
`ifdef FABRIC_CCFF_READBACK_EN
    logic       rd_valid8, rd_valid6;
    logic [3:0] rd_data8, rd_data6;
`endif

    fabric_ccff_loader #(.WORD_W(4), .CHAIN_LEN(8), .CNT_W(4)) u_dut8 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_ready(rdy8),
        .ccff_head(head8), .ccff_shift_en(sen8), .ccff_tail(tail8),
        .busy(busy8), .done(done8)
`ifdef FABRIC_CCFF_READBACK_EN
        , .rd_valid(rd_valid8), .rd_data(rd_data8)
`endif
    );

    fabric_ccff_loader #(.WORD_W(4), .CHAIN_LEN(6), .CNT_W(3)) u_dut6 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_ready(rdy6),
        .ccff_head(head6), .ccff_shift_en(sen6), .ccff_tail(tail6),
        .busy(busy6), .done(done6)
`ifdef FABRIC_CCFF_READBACK_EN
        , .rd_valid(rd_valid6), .rd_data(rd_data6)
`endif
    );

    // Chain model: bit [0] is the head-most flop, the top bit is the tail-most flop.
    logic       chain_clr;
    logic [7:0] c8;
    logic [5:0] c6;
    int         n_sh8, n_sh6, n_acc8, n_acc6, n_done8, n_done6;

    always @(posedge prog_clk) begin
        if (chain_clr) begin
            c8 <= '0; c6 <= '0;
            n_sh8 <= 0; n_sh6 <= 0; n_acc8 <= 0; n_acc6 <= 0; n_done8 <= 0; n_done6 <= 0;
        end else begin
            if (sen8 === 1'b1) begin c8 <= {c8[6:0], head8}; n_sh8 <= n_sh8 + 1; end
            if (sen6 === 1'b1) begin c6 <= {c6[4:0], head6}; n_sh6 <= n_sh6 + 1; end
            if (word_valid && rdy8 === 1'b1) n_acc8 <= n_acc8 + 1;
            if (word_valid && rdy6 === 1'b1) n_acc6 <= n_acc6 + 1;
            if (done8 === 1'b1) n_done8 <= n_done8 + 1;
            if (done6 === 1'b1) n_done6 <= n_done6 + 1;
        end
    end
    assign tail8 = c8[7];
    assign tail6 = c6[5];

`ifdef FABRIC_CCFF_READBACK_EN
    logic [3:0] rdq8[$];
    logic [3:0] rdq6[$];
    always @(posedge prog_clk) begin
        if (rd_valid8 === 1'b1) rdq8.push_back(rd_data8);
        if (rd_valid6 === 1'b1) rdq6.push_back(rd_data6);
    end
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the posedge that completes the handshake.
    task automatic send_word(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rdy8 === 1'b1) begin ok = 1'b1; break; end
            @(negedge prog_clk);
        end
        chk({tag, "_handshake"}, 32'(ok), 32'd1);
        if (ok) @(posedge prog_clk);
    endtask

    task automatic do_load(input logic [3:0] w0, input logic [3:0] w1, input int stall,
                           input bit poke, input string tag);
        bit ok;
        int hits;
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        word_valid = 1'b1; word_data = w0;
        send_word({tag, "_w0"});
        @(negedge prog_clk);
        if (poke) begin
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
        end
        if (stall > 0) begin
            word_valid = 1'b0;
            hits = 0;
            for (int i = 1; i <= stall; i++) begin
                @(negedge prog_clk);
                if (i >= 5 && sen8 !== 1'b0) hits++;
            end
            chk({tag, "_stall_shift_en"}, 32'(hits), 32'd0);
        end
        word_valid = 1'b1; word_data = w1;
        send_word({tag, "_w1"});
        @(negedge prog_clk);
        word_data = 4'h0;   // keep valid high: loader must not take a third word
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done8 === 1'b1) begin ok = 1'b1; break; end
            @(negedge prog_clk);
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, "_busy_in_done"}, 32'(busy8), 32'd1);
            @(negedge prog_clk);
            chk({tag, "_busy_after_done"}, 32'(busy8), 32'd0);
        end
        word_valid = 1'b0;
        repeat (4) @(negedge prog_clk);
    endtask

    typedef struct {
        logic [3:0] w0, w1;
        int         stall;
        bit         poke;
        logic [7:0] img8;
        logic [5:0] img6;
        logic [3:0] rb0, rb1, rb6_1;
    } vec_t;

    vec_t vecs[5];
    int   b_sh8, b_sh6, b_acc8, b_acc6, b_dn8, b_dn6;
    int   base8, base6;

    task automatic snap();
        b_sh8 = n_sh8; b_sh6 = n_sh6; b_acc8 = n_acc8; b_acc6 = n_acc6;
        b_dn8 = n_done8; b_dn6 = n_done6;
    endtask

    task automatic chk_outputs_idle(input string tag);
        chk({tag, "_busy8"}, 32'(busy8), 32'd0);
        chk({tag, "_ready8"}, 32'(rdy8), 32'd0);
        chk({tag, "_head8"}, 32'(head8), 32'd0);
        chk({tag, "_shift_en8"}, 32'(sen8), 32'd0);
        chk({tag, "_done8"}, 32'(done8), 32'd0);
        chk({tag, "_busy6"}, 32'(busy6), 32'd0);
        chk({tag, "_shift_en6"}, 32'(sen6), 32'd0);
        chk({tag, "_ready6"}, 32'(rdy6), 32'd0);
`ifdef FABRIC_CCFF_READBACK_EN
        chk({tag, "_rd_valid8"}, 32'(rd_valid8), 32'd0);
        chk({tag, "_rd_data8"}, 32'(rd_data8), 32'd0);
`endif
    endtask

    initial begin
        //        w0    w1   stall poke img8   img6   rb0   rb1   rb6_1
        vecs[0] = '{4'h5, 4'hA, 0,  1'b0, 8'hA5, 6'h29, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{4'hF, 4'h3, 0,  1'b0, 8'hFC, 6'h3F, 4'h5, 4'hA, 4'h2};
        vecs[2] = '{4'h5, 4'hA, 14, 1'b0, 8'hA5, 6'h29, 4'hF, 4'h3, 4'h3};
        vecs[3] = '{4'h3, 4'hC, 0,  1'b0, 8'hC3, 6'h30, 4'h5, 4'hA, 4'h2};
        vecs[4] = '{4'h3, 4'hC, 0,  1'b1, 8'hC3, 6'h30, 4'h3, 4'hC, 4'h0};

        pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 4'h0; chain_clr = 1'b1;
        repeat (3) @(negedge prog_clk);
        chk_outputs_idle("reset");
        chain_clr = 1'b0;
        pReset = 1'b0;
        repeat (2) @(negedge prog_clk);

        for (int v = 0; v < 5; v++) begin
            snap();
`ifdef FABRIC_CCFF_READBACK_EN
            base8 = rdq8.size(); base6 = rdq6.size();
`endif
            do_load(vecs[v].w0, vecs[v].w1, vecs[v].stall, vecs[v].poke, $sformatf("v%0d", v));
            chk($sformatf("v%0d_shifts8", v), 32'(n_sh8 - b_sh8), 32'd8);
            chk($sformatf("v%0d_shifts6", v), 32'(n_sh6 - b_sh6), 32'd6);
            chk($sformatf("v%0d_words8", v), 32'(n_acc8 - b_acc8), 32'd2);
            chk($sformatf("v%0d_words6", v), 32'(n_acc6 - b_acc6), 32'd2);
            chk($sformatf("v%0d_dones8", v), 32'(n_done8 - b_dn8), 32'd1);
            chk($sformatf("v%0d_dones6", v), 32'(n_done6 - b_dn6), 32'd1);
            chk($sformatf("v%0d_image8", v), 32'(c8), 32'(vecs[v].img8));
            chk($sformatf("v%0d_image6", v), 32'(c6), 32'(vecs[v].img6));
`ifdef FABRIC_CCFF_READBACK_EN
            chk($sformatf("v%0d_rd_count8", v), 32'(rdq8.size() - base8), 32'd2);
            chk($sformatf("v%0d_rd_count6", v), 32'(rdq6.size() - base6), 32'd2);
            if (rdq8.size() >= base8 + 2) begin
                chk($sformatf("v%0d_rd8_w0", v), 32'(rdq8[base8]), 32'(vecs[v].rb0));
                chk($sformatf("v%0d_rd8_w1", v), 32'(rdq8[base8 + 1]), 32'(vecs[v].rb1));
            end
            if (rdq6.size() >= base6 + 2) begin
                chk($sformatf("v%0d_rd6_w0", v), 32'(rdq6[base6]), 32'(vecs[v].rb0));
                chk($sformatf("v%0d_rd6_w1", v), 32'(rdq6[base6 + 1]), 32'(vecs[v].rb6_1));
            end
`endif
        end

        // Reset while the fourth bit of the first word is being issued.
        snap();
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        word_valid = 1'b1; word_data = 4'h5;
        send_word("rst_w0");
        repeat (4) @(negedge prog_clk);
        chk("rst_pre_busy8", 32'(busy8), 32'd1);
        chk("rst_pre_shift_en8", 32'(sen8), 32'd1);
        word_valid = 1'b0;
        pReset = 1'b1;
        @(negedge prog_clk);
        chk_outputs_idle("midload_reset");
        pReset = 1'b0;
        repeat (5) @(negedge prog_clk);
        chk("rst_no_done8", 32'(n_done8 - b_dn8), 32'd0);
        chk("rst_no_done6", 32'(n_done6 - b_dn6), 32'd0);
        chk("rst_stay_idle8", 32'(busy8), 32'd0);

        snap();
        do_load(4'h6, 4'h9, 0, 1'b0, "reload");
        chk("reload_shifts8", 32'(n_sh8 - b_sh8), 32'd8);
        chk("reload_shifts6", 32'(n_sh6 - b_sh6), 32'd6);
        chk("reload_words8", 32'(n_acc8 - b_acc8), 32'd2);
        chk("reload_dones8", 32'(n_done8 - b_dn8), 32'd1);
        chk("reload_image8", 32'(c8), 32'h69);
        chk("reload_image6", 32'(c6), 32'h1A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
